// File: rtl/stream_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_codec_pkg
// Brief    : Shared types and constants for the record codec stream blocks.
// Revision : 1.0
// ============================================================================
package stream_codec_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t VARIABLEFIELD_DELIMITER = 8'h2c;
   localparam int    FIXEDFIELD_LENGTH_BYTES = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EMIT  = 2'd1,
      FLUSH = 2'd2
   } packer_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_byte_aligner.sv
`default_nettype none
// ============================================================================
// Module   : stream_byte_aligner
// Brief    : Places the first len bytes of a record at a byte offset inside a
//            wider buffer image; bytes outside the record are driven zero.
// Revision : 1.0
// ============================================================================
module stream_byte_aligner
   import stream_codec_pkg::*;
#(
   parameter int W         = 8,
   parameter int MAX_BYTES = 34,
   parameter int DEPTH     = MAX_BYTES + W - 1,
   parameter int LEN_W     = $clog2(MAX_BYTES + 1),
   parameter int OFF_W     = $clog2(W)
) (
   input  logic [MAX_BYTES-1:0][7:0] recordIn,
   input  logic [LEN_W-1:0]          len,
   input  logic [OFF_W-1:0]          offset,
   output logic [DEPTH-1:0][7:0]     aligned
);

   byte_t [DEPTH-1:0] shifted;

   // Mask off bytes beyond len, then shift left by 1/2/4... byte stages.
   always_comb begin
      shifted = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (LEN_W'(i) < len) shifted[i] = recordIn[i];
      end
      for (int s = 0; s < OFF_W; s++) begin
         if (offset[s]) shifted = shifted << (8 << s);
      end
      aligned = shifted;
   end

endmodule
`default_nettype wire

// File: rtl/stream_record_packer.sv
`default_nettype none
// ============================================================================
// Module   : stream_record_packer
// Brief    : Packs variable-length aligned records back-to-back onto a
//            W-byte output stream, carrying leftover bytes into the next record.
//            Optional flush/keep/last support: STREAM_RECORD_PACKER_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module stream_record_packer
   import stream_codec_pkg::*;
#(
   parameter int DATA_BUS_WIDTH_BYTES = 8,
   parameter int MAX_RECORD_BYTES     = 34
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [MAX_RECORD_BYTES-1:0][7:0]         recordIn,
   input  logic [$clog2(MAX_RECORD_BYTES+1)-1:0]    recordByteLength,
   input  logic                                     recordValid,
   output logic                                     recordReady,
   output logic [DATA_BUS_WIDTH_BYTES-1:0][7:0]     dataOut,
   output logic                                     dataOutValid,
   input  logic                                     dataOutReady,
   output logic                                     lengthError
`ifdef STREAM_RECORD_PACKER_FLUSH_EN
   ,
   input  logic                                     flushIn,
   output logic [DATA_BUS_WIDTH_BYTES-1:0]          dataOutKeep,
   output logic                                     dataOutLast
`endif
);

   localparam int W     = DATA_BUS_WIDTH_BYTES;
   localparam int MAX   = MAX_RECORD_BYTES;
   localparam int DEPTH = MAX + W - 1;
   localparam int LEN_W = $clog2(MAX + 1);
   localparam int REM_W = $clog2(MAX + W);
   localparam int OFF_W = $clog2(W);

   packer_state_e           state_q, state_d;
   logic [DEPTH-1:0][7:0]   buffer_q, buffer_d;
   logic [REM_W-1:0]        rem_q, rem_d;
   logic [W-1:0][7:0]       data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    ready_q, ready_d;
   logic                    err_q, err_d;

   logic [LEN_W-1:0]        len_c;
   logic [REM_W-1:0]        total;
   logic [DEPTH-1:0][7:0]   aligned;
   logic                    accept;

`ifdef STREAM_RECORD_PACKER_FLUSH_EN
   logic [W-1:0]            keep_q, keep_d;
   logic                    last_q, last_d;
   logic                    flush_pend_q, flush_pend_d;
   logic                    flush_clr;
`endif

   assign len_c  = (recordByteLength > LEN_W'(MAX)) ? LEN_W'(MAX) : recordByteLength;
   assign total  = rem_q + REM_W'(len_c);
   assign accept = recordValid && ready_q;

   stream_byte_aligner #(
      .W         (W),
      .MAX_BYTES (MAX),
      .DEPTH     (DEPTH),
      .LEN_W     (LEN_W),
      .OFF_W     (OFF_W)
   ) u_aligner (
      .recordIn (recordIn),
      .len      (len_c),
      .offset   (rem_q[OFF_W-1:0]),
      .aligned  (aligned)
   );

   always_comb begin
      state_d  = state_q;
      buffer_d = buffer_q;
      rem_d    = rem_q;
      data_d   = data_q;
      valid_d  = valid_q;
      ready_d  = ready_q;
      err_d    = err_q | (accept && (recordByteLength > LEN_W'(MAX)));
`ifdef STREAM_RECORD_PACKER_FLUSH_EN
      keep_d    = keep_q;
      last_d    = last_q;
      flush_clr = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               // Bytes above the residue are always zero, so OR merges the record in.
               buffer_d = buffer_q | aligned;
               rem_d    = total;
               if (total >= REM_W'(W)) begin
                  state_d = EMIT;
                  valid_d = 1'b1;
                  data_d  = buffer_d[W-1:0];
                  ready_d = 1'b0;
`ifdef STREAM_RECORD_PACKER_FLUSH_EN
                  keep_d  = '1;
                  last_d  = 1'b0;
`endif
               end
            end
`ifdef STREAM_RECORD_PACKER_FLUSH_EN
            else if (flush_pend_q) begin
               flush_clr = 1'b1;
               if (rem_q != '0) begin
                  state_d = FLUSH;
                  valid_d = 1'b1;
                  data_d  = buffer_q[W-1:0];
                  ready_d = 1'b0;
                  last_d  = 1'b1;
                  for (int i = 0; i < W; i++) keep_d[i] = (REM_W'(i) < rem_q);
               end
            end
`endif
         end
         EMIT: begin
            if (valid_q && dataOutReady) begin
               buffer_d = buffer_q >> (8 * W);
               rem_d    = rem_q - REM_W'(W);
               if (rem_d >= REM_W'(W)) begin
                  data_d = buffer_d[W-1:0];
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  data_d  = '0;
                  ready_d = 1'b1;
`ifdef STREAM_RECORD_PACKER_FLUSH_EN
                  keep_d  = '0;
`endif
               end
            end
         end
`ifdef STREAM_RECORD_PACKER_FLUSH_EN
         FLUSH: begin
            if (valid_q && dataOutReady) begin
               state_d  = IDLE;
               buffer_d = '0;
               rem_d    = '0;
               valid_d  = 1'b0;
               data_d   = '0;
               keep_d   = '0;
               last_d   = 1'b0;
               ready_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

`ifdef STREAM_RECORD_PACKER_FLUSH_EN
   assign flush_pend_d = (flush_pend_q & ~flush_clr) | flushIn;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keep_q       <= '0;
         last_q       <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         keep_q       <= keep_d;
         last_q       <= last_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign dataOutKeep = keep_q;
   assign dataOutLast = last_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         buffer_q <= '0;
         rem_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         buffer_q <= buffer_d;
         rem_q    <= rem_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   assign recordReady  = ready_q;
   assign dataOut      = data_q;
   assign dataOutValid = valid_q;
   assign lengthError  = err_q;

endmodule
`default_nettype wire
